// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction field bounds, LDR/STR decode and
// the memory-stage state encoding.
package pipeline_pkg;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 25;
    localparam int unsigned RT_MSB  = 15;
    localparam int unsigned RT_LSB  = 12;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int unsigned RT_W    = RT_MSB - RT_LSB + 1;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 7;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    function automatic logic is_ldr(input logic [OPC_W-1:0] op);
        return (op[6:4] == 3'b110) || (op[6:3] == 4'b1000);
    endfunction

    function automatic logic is_str(input logic [OPC_W-1:0] op);
        return (op[6:4] == 3'b111) || (op[6:3] == 4'b1001);
    endfunction

endpackage

// File: rtl/memory_pipeline_unit.sv
// Enable-gated instr/pc stage register; exposes the opcode and rt fields of
// the held instruction.
module memory_pipeline_unit
    import pipeline_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [OPC_W-1:0]   opcode_o,
    output logic [RT_W-1:0]    rt_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_q;

    // Stage register: loads only on an accepted instruction, otherwise holds.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            instr_q <= {INSTR_W{1'b0}};
            pc_q    <= {PC_W{1'b0}};
        end else if (en_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else begin
            instr_q <= instr_q;
            pc_q    <= pc_q;
        end
    end

    assign instr_o  = instr_q;
    assign pc_o     = pc_q;
    assign opcode_o = instr_q[OPC_MSB:OPC_LSB];
    assign rt_o     = instr_q[RT_MSB:RT_LSB];

endmodule

// File: rtl/ldr_str_memory_unit.sv
// Memory-access stage: accepts instructions from execute, runs LDR/STR through
// a req/ack handshake with timeout, and retires each one to writeback.
module ldr_str_memory_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               valid_in,
    output logic               stall_out,
    output logic               mem_req,
    output logic               mem_w_en,
    input  logic               mem_ack,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic [OPC_W-1:0]   opcode,
    output logic [RT_W-1:0]    rt,
    output logic               valid_out,
    output logic               mem_err
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    mem_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               w_en_q, w_en_d;
    logic               req_s;
    logic               stall_s;
    logic               accept_s;
    logic               mem_op_s;
    logic [OPC_W-1:0]   in_op_s;

    assign in_op_s  = instr_in[OPC_MSB:OPC_LSB];
    assign mem_op_s = is_ldr(in_op_s) || is_str(in_op_s);
    assign accept_s = valid_in && !stall_s;

    // State, timeout counter and retire pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            w_en_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            w_en_q  <= w_en_d;
        end
    end

    // Next state: an ack on the timeout cycle wins over the abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        w_en_d  = w_en_q;
        case (state_q)
            IDLE: begin
                if (accept_s && mem_op_s) begin
                    state_d = ACCESS;
                    cnt_d   = {CNT_W{1'b0}};
                    w_en_d  = is_str(in_op_s);
                end else if (accept_s) begin
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ack) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = ACCESS;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Outputs decoded from the state register only.
    always_comb begin
        req_s   = 1'b0;
        stall_s = 1'b0;
        case (state_q)
            IDLE: begin
                req_s   = 1'b0;
                stall_s = 1'b0;
            end
            ACCESS: begin
                req_s   = 1'b1;
                stall_s = 1'b1;
            end
            default: begin
                req_s   = 1'b0;
                stall_s = 1'b0;
            end
        endcase
    end

    memory_pipeline_unit u_stage (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .en_i     (accept_s),
        .instr_i  (instr_in),
        .pc_i     (pc_in),
        .instr_o  (instr_out),
        .pc_o     (pc_out),
        .opcode_o (opcode),
        .rt_o     (rt)
    );

    assign stall_out = stall_s;
    assign mem_req   = req_s;
    assign mem_w_en  = req_s & w_en_q;
    assign valid_out = valid_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_ldr_str_memory_unit.sv
// Directed bench for ldr_str_memory_unit with a transaction-level reference
// model updated every clock and compared against all outputs.
module tb_ldr_str_memory_unit;

    localparam int ACK_T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_in;
    logic [6:0]  pc_in;
    logic        valid_in;
    logic        stall_out;
    logic        mem_req;
    logic        mem_w_en;
    logic        mem_ack;
    logic [31:0] instr_out;
    logic [6:0]  pc_out;
    logic [6:0]  opcode;
    logic [3:0]  rt;
    logic        valid_out;
    logic        mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_busy;
    int          m_waited;
    logic [31:0] m_instr;
    logic [6:0]  m_pc;
    bit          m_store;
    bit          m_valid;
    bit          m_err;

    ldr_str_memory_unit #(.ACK_TIMEOUT(ACK_T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr_in  (instr_in),
        .pc_in     (pc_in),
        .valid_in  (valid_in),
        .stall_out (stall_out),
        .mem_req   (mem_req),
        .mem_w_en  (mem_w_en),
        .mem_ack   (mem_ack),
        .instr_out (instr_out),
        .pc_out    (pc_out),
        .opcode    (opcode),
        .rt        (rt),
        .valid_out (valid_out),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    // LDR opcodes: 0x60-0x6F and 0x40-0x47; STR: 0x70-0x7F and 0x48-0x4F
    function automatic bit m_is_ldr(input int op);
        return (op >= 96 && op <= 111) || (op >= 64 && op <= 71);
    endfunction

    function automatic bit m_is_str(input int op);
        return (op >= 112 && op <= 127) || (op >= 72 && op <= 79);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, then compare every output.
    task automatic tick();
        bit was_busy;
        int op;
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_waited = 0; m_instr = '0; m_pc = '0;
            m_store = 0; m_valid = 0; m_err = 0;
        end else begin
            was_busy = m_busy;
            m_valid = 0;
            m_err = 0;
            if (was_busy) begin
                m_waited++;
                if (mem_ack) begin
                    m_busy = 0; m_valid = 1;
                end else if (m_waited == ACK_T) begin
                    m_busy = 0; m_valid = 1; m_err = 1;
                end
            end else if (valid_in) begin
                m_instr = instr_in;
                m_pc = pc_in;
                op = int'(instr_in[31:25]);
                if (m_is_ldr(op) || m_is_str(op)) begin
                    m_busy = 1; m_waited = 0; m_store = m_is_str(op);
                end else begin
                    m_valid = 1;
                end
            end
        end
        #2;
        chk("model_stall", {31'd0, stall_out}, {31'd0, m_busy});
        chk("model_req", {31'd0, mem_req}, {31'd0, m_busy});
        if (m_busy) chk("model_wen", {31'd0, mem_w_en}, {31'd0, m_store});
        chk("model_valid", {31'd0, valid_out}, {31'd0, m_valid});
        chk("model_err", {31'd0, mem_err}, {31'd0, m_err});
        chk("model_instr", instr_out, m_instr);
        chk("model_pc", {25'd0, pc_out}, {25'd0, m_pc});
        chk("model_opcode", {25'd0, opcode}, {25'd0, m_instr[31:25]});
        chk("model_rt", {28'd0, rt}, {28'd0, m_instr[15:12]});
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [6:0] pc);
        valid_in = v;
        instr_in = ins;
        pc_in = pc;
    endtask

    initial begin
        m_busy = 0; m_waited = 0; m_instr = '0; m_pc = '0;
        m_store = 0; m_valid = 0; m_err = 0;
        rst_n = 1'b0;
        mem_ack = 1'b0;
        drive(1'b1, 32'hC0003000, 7'd5);

        // 1: reset with valid_in asserted
        tick();
        tick();
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", {25'd0, pc_out}, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 32'd0, 7'd0);
        mem_ack = 1'b1;           // ack in IDLE must be ignored
        tick();
        mem_ack = 1'b0;

        // 2: back-to-back ALU instructions
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'h02000000, 7'(i));
            tick();
            chk("alu_valid", {31'd0, valid_out}, 32'd1);
            chk("alu_pc", {25'd0, pc_out}, i);
            chk("alu_stall", {31'd0, stall_out}, 32'd0);
        end
        drive(1'b0, 32'd0, 7'd0);
        tick();
        chk("alu_done", {31'd0, valid_out}, 32'd0);

        // 3: LDR acked on the third request cycle
        drive(1'b1, 32'hC0003000, 7'd10);
        tick();
        drive(1'b0, 32'd0, 7'd0);
        for (int i = 0; i < 3; i++) begin
            chk("ldr_req", {31'd0, mem_req}, 32'd1);
            chk("ldr_wen", {31'd0, mem_w_en}, 32'd0);
            chk("ldr_stall", {31'd0, stall_out}, 32'd1);
            mem_ack = (i == 2);
            tick();
        end
        mem_ack = 1'b0;
        chk("ldr_valid", {31'd0, valid_out}, 32'd1);
        chk("ldr_opcode", {25'd0, opcode}, 32'h60);
        chk("ldr_rt", {28'd0, rt}, 32'd3);
        chk("ldr_pc", {25'd0, pc_out}, 32'd10);
        chk("ldr_err", {31'd0, mem_err}, 32'd0);
        chk("ldr_req_off", {31'd0, mem_req}, 32'd0);

        // 4: STR acked at once, ALU waiting behind it
        drive(1'b1, 32'hE0005000, 7'd20);
        tick();
        chk("str_req", {31'd0, mem_req}, 32'd1);
        chk("str_wen", {31'd0, mem_w_en}, 32'd1);
        drive(1'b1, 32'h02000000, 7'd21);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("str_valid", {31'd0, valid_out}, 32'd1);
        chk("str_pc", {25'd0, pc_out}, 32'd20);
        chk("str_stall", {31'd0, stall_out}, 32'd0);
        tick();
        chk("str_alu_valid", {31'd0, valid_out}, 32'd1);
        chk("str_alu_pc", {25'd0, pc_out}, 32'd21);
        drive(1'b0, 32'd0, 7'd0);
        tick();

        // 5: LDR never acked -> timeout
        drive(1'b1, 32'hC0003000, 7'd30);
        tick();
        drive(1'b0, 32'd0, 7'd0);
        for (int i = 0; i < 4; i++) begin
            chk("to_req", {31'd0, mem_req}, 32'd1);
            tick();
        end
        chk("to_req_off", {31'd0, mem_req}, 32'd0);
        chk("to_valid", {31'd0, valid_out}, 32'd1);
        chk("to_err", {31'd0, mem_err}, 32'd1);
        tick();
        chk("to_err_pulse", {31'd0, mem_err}, 32'd0);

        // 6: reset in the middle of an access, late ack afterwards
        drive(1'b1, 32'hC0003000, 7'd40);
        tick();
        drive(1'b0, 32'd0, 7'd0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_req", {31'd0, mem_req}, 32'd0);
        chk("mrst_valid", {31'd0, valid_out}, 32'd0);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        tick();
        chk("mrst_late_ack", {31'd0, valid_out}, 32'd0);
        mem_ack = 1'b0;
        tick();

        // 7: alternate encodings; ack exactly on the timeout edge is success
        drive(1'b1, 32'h90001000, 7'd50);
        tick();
        drive(1'b0, 32'd0, 7'd0);
        chk("alt_str_wen", {31'd0, mem_w_en}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            tick();
        end
        mem_ack = 1'b0;
        chk("edge_valid", {31'd0, valid_out}, 32'd1);
        chk("edge_err", {31'd0, mem_err}, 32'd0);
        drive(1'b1, 32'h80002000, 7'd51);
        tick();
        drive(1'b0, 32'd0, 7'd0);
        chk("alt_ldr_req", {31'd0, mem_req}, 32'd1);
        chk("alt_ldr_wen", {31'd0, mem_w_en}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("alt_ldr_rt", {28'd0, rt}, 32'd2);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
